// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HOLD = 3'd4
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES      = 4;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter: redirect mux with word alignment and sequential increment.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] target,
  input  logic             advance,
  output logic [WIDTH-1:0] pc
);

  localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(INSTR_BYTES - 1);

  logic [WIDTH-1:0] pc_r;

  // Redirect wins over sequential advance; targets are forced word aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= target & ALIGN_MASK;
    end else if (advance) begin
      pc_r <= pc_r + STEP;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, single-entry instruction
// buffer towards decode, and redirect handling that drops stale fetches.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             imem_req_valid_o,
  output logic [WIDTH-1:0] imem_req_addr_o,
  input  logic             imem_req_ready_i,
  input  logic             imem_rsp_valid_i,
  input  logic [31:0]      imem_rsp_data_i,
  output logic             fetch_valid_o,
  input  logic             fetch_ready_i,
  output logic [WIDTH-1:0] fetch_pc_o,
  output logic [WIDTH-1:0] fetch_pre_pc_o,
  output logic [31:0]      fetch_instr_o
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);

  fetch_state_t     state_r;
  logic             req_valid_r;
  logic             buf_valid_r;
  logic [WIDTH-1:0] fetch_pc_r;
  logic [31:0]      fetch_instr_r;
  logic [WIDTH-1:0] pc_s;
  logic             load_s;
  logic             advance_s;
  logic             handshake_s;

  assign handshake_s = req_valid_r & imem_req_ready_i;

  // PC control: any redirect outside IDLE reloads, a HOLD transfer advances.
  always_comb begin
    load_s    = 1'b0;
    advance_s = 1'b0;
    case (state_r)
      REQ, WAIT, DROP: begin
        load_s = redirect_valid_i;
      end
      HOLD: begin
        load_s    = redirect_valid_i;
        advance_s = fetch_ready_i & ~redirect_valid_i;
      end
      default: begin
        load_s    = 1'b0;
        advance_s = 1'b0;
      end
    endcase
  end

  fetch_pc_gen #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .target  (redirect_pc_i),
    .advance (advance_s),
    .pc      (pc_s)
  );

  // Sequencer FSM with registered request-valid and instruction buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      req_valid_r   <= 1'b0;
      buf_valid_r   <= 1'b0;
      fetch_pc_r    <= RESET_PC;
      fetch_instr_r <= NOP_INSTR;
    end else begin
      case (state_r)
        IDLE: begin
          state_r     <= REQ;
          req_valid_r <= 1'b1;
        end
        REQ: begin
          if (handshake_s) begin
            state_r     <= redirect_valid_i ? DROP : WAIT;
            req_valid_r <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid_i) begin
            if (redirect_valid_i) begin
              state_r     <= REQ;
              req_valid_r <= 1'b1;
            end else begin
              state_r       <= HOLD;
              buf_valid_r   <= 1'b1;
              fetch_pc_r    <= pc_s;
              fetch_instr_r <= imem_rsp_data_i;
            end
          end else if (redirect_valid_i) begin
            state_r <= DROP;
          end
        end
        DROP: begin
          // The response still owed for the cancelled request is thrown away.
          if (imem_rsp_valid_i) begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid_i || fetch_ready_i) begin
            state_r     <= REQ;
            req_valid_r <= 1'b1;
            buf_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_valid_r <= 1'b0;
          buf_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid_o = req_valid_r;
  assign imem_req_addr_o  = pc_s;
  // A same-cycle redirect hides the buffered instruction from decode.
  assign fetch_valid_o    = buf_valid_r & ~redirect_valid_i;
  assign fetch_pc_o       = fetch_pc_r;
  assign fetch_pre_pc_o   = fetch_pc_r + STEP;
  assign fetch_instr_o    = fetch_instr_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with an inline memory responder.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        fetch_valid_o;
  logic        fetch_ready_i;
  logic [31:0] fetch_pc_o;
  logic [31:0] fetch_pre_pc_o;
  logic [31:0] fetch_instr_o;

  int errors = 0;
  int checks = 0;
  bit auto_rsp;

  fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_ready_i    (fetch_ready_i),
    .fetch_pc_o       (fetch_pc_o),
    .fetch_pre_pc_o   (fetch_pre_pc_o),
    .fetch_instr_o    (fetch_instr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; the modelled memory answers a handshake the next cycle with ~addr.
  task automatic tick();
    logic        hs;
    logic [31:0] addr;
    hs   = imem_req_valid_o && imem_req_ready_i;
    addr = imem_req_addr_o;
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      imem_rsp_valid_i = hs;
      imem_rsp_data_i  = hs ? ~addr : 32'h0;
    end
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
    fetch_ready_i    = 1'b1;
    auto_rsp         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
    fetch_ready_i    = 1'b1;
    auto_rsp         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid_o); end
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got=%b exp=0", fetch_valid_o); end
    checks++; if (fetch_pc_o !== 32'h8000_0000) begin errors++; $display("FAIL reset_fetch_pc got=%h exp=80000000", fetch_pc_o); end
    checks++; if (fetch_pre_pc_o !== 32'h8000_0004) begin errors++; $display("FAIL reset_pre_pc got=%h exp=80000004", fetch_pre_pc_o); end
    checks++; if (fetch_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got=%h exp=00000013", fetch_instr_o); end
    checks++; if (imem_req_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr got=%h exp=80000000", imem_req_addr_o); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    logic [31:0] exp_pp [3];
    exp_pc = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    exp_in = '{32'h7FFF_FFFF, 32'h7FFF_FFFB, 32'h7FFF_FFF7};
    exp_pp = '{32'h8000_0004, 32'h8000_0008, 32'h8000_000C};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();  // REQ
      checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== exp_pc[i]) begin errors++; $display("FAIL stream_req[%0d] got=%b/%h exp=1/%h", i, imem_req_valid_o, imem_req_addr_o, exp_pc[i]); end
      checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL stream_noval_req[%0d] got=%b exp=0", i, fetch_valid_o); end
      tick();  // WAIT
      checks++; if (imem_req_valid_o !== 1'b0 || fetch_valid_o !== 1'b0) begin errors++; $display("FAIL stream_wait[%0d] got=%b/%b exp=0/0", i, imem_req_valid_o, fetch_valid_o); end
      tick();  // HOLD
      checks++; if (fetch_valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, fetch_valid_o); end
      checks++; if (fetch_pc_o !== exp_pc[i] || fetch_instr_o !== exp_in[i]) begin errors++; $display("FAIL stream_data[%0d] got=%h/%h exp=%h/%h", i, fetch_pc_o, fetch_instr_o, exp_pc[i], exp_in[i]); end
      checks++; if (fetch_pre_pc_o !== exp_pp[i]) begin errors++; $display("FAIL stream_pre_pc[%0d] got=%h exp=%h", i, fetch_pre_pc_o, exp_pp[i]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick(); tick();  // through first instruction, now REQ @4
    fetch_ready_i = 1'b0;
    tick(); tick();                  // WAIT, HOLD @4
    for (int i = 0; i < 5; i++) begin
      checks++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 32'h8000_0004 || fetch_instr_o !== 32'h7FFF_FFFB) begin errors++; $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/80000004/7ffffffb", i, fetch_valid_o, fetch_pc_o, fetch_instr_o); end
      checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL stall_noreq[%0d] got=%b exp=0", i, imem_req_valid_o); end
      tick();
    end
    fetch_ready_i = 1'b1;
    tick();
    checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0008) begin errors++; $display("FAIL stall_release got=%b/%h exp=1/80000008", imem_req_valid_o, imem_req_addr_o); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    auto_rsp = 1'b0;
    tick(); tick();                  // REQ, WAIT (no response yet)
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0100;
    tick();                          // DROP
    redirect_valid_i = 1'b0;
    checks++; if (imem_req_valid_o !== 1'b0 || imem_req_addr_o !== 32'h8000_0100) begin errors++; $display("FAIL rdw_drop got=%b/%h exp=0/80000100", imem_req_valid_o, imem_req_addr_o); end
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hDEAD_BEEF;
    #1;
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL rdw_stale_valid got=%b exp=0", fetch_valid_o); end
    tick();                          // REQ to target
    imem_rsp_valid_i = 1'b0;
    checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0100) begin errors++; $display("FAIL rdw_req got=%b/%h exp=1/80000100", imem_req_valid_o, imem_req_addr_o); end
    checks++; if (fetch_valid_o !== 1'b0 || fetch_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL rdw_discard got=%b/%h exp=0/00000013", fetch_valid_o, fetch_instr_o); end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    tick(); tick(); tick();          // HOLD @0
    fetch_ready_i    = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0203;
    #1;
    checks++; if (fetch_valid_o !== 1'b0) begin errors++; $display("FAIL rdh_valid got=%b exp=0", fetch_valid_o); end
    tick();
    redirect_valid_i = 1'b0;
    checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0200) begin errors++; $display("FAIL rdh_req got=%b/%h exp=1/80000200", imem_req_valid_o, imem_req_addr_o); end
    tick(); tick();
    checks++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 32'h8000_0200 || fetch_instr_o !== 32'h7FFF_FDFF) begin errors++; $display("FAIL rdh_target got=%b/%h/%h exp=1/80000200/7ffffdff", fetch_valid_o, fetch_pc_o, fetch_instr_o); end
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    auto_rsp = 1'b0;
    tick(); tick();                  // REQ, WAIT
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h1234_5678;
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'h8000_0300;
    tick();
    imem_rsp_valid_i = 1'b0;
    redirect_valid_i = 1'b0;
    checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0300) begin errors++; $display("FAIL rdr_req got=%b/%h exp=1/80000300", imem_req_valid_o, imem_req_addr_o); end
    checks++; if (fetch_valid_o !== 1'b0 || fetch_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL rdr_nohold got=%b/%h exp=0/00000013", fetch_valid_o, fetch_instr_o); end
    imem_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0300) begin errors++; $display("FAIL backpressure[%0d] got=%b/%h exp=1/80000300", i, imem_req_valid_o, imem_req_addr_o); end
    end
    imem_req_ready_i = 1'b1;
    tick();
    checks++; if (imem_req_valid_o !== 1'b0) begin errors++; $display("FAIL backpressure_accept got=%b exp=0", imem_req_valid_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_req_ready_i = 1'b0;
    tick();                          // REQ, not accepted
    redirect_valid_i = 1'b1;
    redirect_pc_i    = 32'hFFFF_FFFC;
    tick();
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b1;
    checks++; if (imem_req_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_req_addr_o); end
    tick(); tick();                  // WAIT, HOLD
    checks++; if (fetch_pc_o !== 32'hFFFF_FFFC || fetch_pre_pc_o !== 32'h0000_0000 || fetch_instr_o !== 32'h0000_0003) begin errors++; $display("FAIL wrap_hold got=%h/%h/%h exp=fffffffc/00000000/00000003", fetch_pc_o, fetch_pre_pc_o, fetch_instr_o); end
    tick();
    checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", imem_req_valid_o, imem_req_addr_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); tick(); tick(); tick(); tick();  // second fetch, now WAIT @4
    checks++; if (imem_req_addr_o !== 32'h8000_0004 || fetch_instr_o !== 32'h7FFF_FFFF) begin errors++; $display("FAIL rstmid_pre got=%h/%h exp=80000004/7fffffff", imem_req_addr_o, fetch_instr_o); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req_addr_o !== 32'h8000_0000 || imem_req_valid_o !== 1'b0 || fetch_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_req got=%h/%b/%b exp=80000000/0/0", imem_req_addr_o, imem_req_valid_o, fetch_valid_o); end
    checks++; if (fetch_pc_o !== 32'h8000_0000 || fetch_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL rstmid_buf got=%h/%h exp=80000000/00000013", fetch_pc_o, fetch_instr_o); end
    auto_rsp         = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hCAFE_F00D;
    rst              = 1'b0;
    tick();                          // IDLE -> REQ, stale response ignored
    imem_rsp_valid_i = 1'b0;
    checks++; if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h8000_0000 || fetch_valid_o !== 1'b0 || fetch_instr_o !== 32'h0000_0013) begin errors++; $display("FAIL rstmid_stale got=%b/%h/%b/%h exp=1/80000000/0/00000013", imem_req_valid_o, imem_req_addr_o, fetch_valid_o, fetch_instr_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_rsp();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
